// File: rtl/bus_fifo.sv
// bus_fifo: synchronous first-word-fall-through FIFO for Bus_t words.
// Absorbs the registered Bus_t stream from the flip-flop stage and decouples
// the producer from a consumer that can stall. Words pass through unmodified.
// It also reports occupancy and a sticky overflow flag.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst    synchronous active-high reset
//   i_valid  producer offers i_D this cycle
//   i_D      write word (Bus_t)
//   o_ready  FIFO can accept a word (!o_full)
//   o_Q      head-of-queue word, '0 when empty
//   o_valid  o_Q holds a valid word (!o_empty)
//   i_ready  consumer accepts o_Q this cycle
//   o_count  number of stored words, 0..DEPTH
//   o_full   o_count == DEPTH
//   o_empty  o_count == 0
//   o_ovf    sticky: a word was offered while full

package bus_fifo_pkg;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned DATA_W = 8;

    // Bus word: tag in the upper bits, data in the lower bits.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } Bus_t;
endpackage

module bus_fifo
    import bus_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  Bus_t          i_D,
    output logic          o_ready,
    output Bus_t          o_Q,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    Bus_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          push, pop;

    // Acceptance uses only the registered flags, so no handshake-to-handshake path.
    assign push = i_valid && !full_q;
    assign pop  = !empty_q && i_ready;

    // Next-state for pointers, occupancy and flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A refused offer is recorded even if a pop frees a slot this edge.
        if (i_valid && full_q) begin
            ovf_d = 1'b1;
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    // Control state register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; writes are blocked during reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && push) begin
            mem_q[wptr_q] <= i_D;
        end
    end

    // Fall-through head word, forced to zero when empty.
    assign o_Q     = empty_q ? Bus_t'('0) : mem_q[rptr_q];
    assign o_valid = !empty_q;
    assign o_ready = !full_q;
    assign o_count = count_q;
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_bus_fifo.sv
// tb_bus_fifo: self-checking bench for bus_fifo (DEPTH=8, 12-bit Bus_t).
// A queue-based model tracks expected contents and the sticky overflow flag.

module tb_bus_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [11:0]   d_in;
    logic          ready_in;
    logic          ready_out;
    logic [11:0]   q_out;
    logic          valid_out;
    logic [CW-1:0] count_out;
    logic          full_out;
    logic          empty_out;
    logic          ovf_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] mq[$];
    logic        m_ovf;

    always #5 clk = ~clk;

    bus_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid_in),
        .i_D     (d_in),
        .o_ready (ready_out),
        .o_Q     (q_out),
        .o_valid (valid_out),
        .i_ready (ready_in),
        .o_count (count_out),
        .o_full  (full_out),
        .o_empty (empty_out),
        .o_ovf   (ovf_out)
    );

    // Drive one cycle of inputs, advance the model, then settle past the edge.
    task automatic tick(input logic v, input logic [11:0] d, input logic r, input logic rs);
        valid_in = v;
        d_in     = d;
        ready_in = r;
        rst      = rs;
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (mq.size() > 0) && r;
            do_push = v && (mq.size() < DEPTH);
            if (v && mq.size() == DEPTH) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 12'hABC, 1'b1, 1'b1);
        tick(1'b1, 12'hABC, 1'b1, 1'b1);
        n_tests++;
        if (count_out !== CW'(0)) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_out); end
        n_tests++;
        if (empty_out !== 1'b1 || full_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got empty=%b full=%b want 1/0", empty_out, full_out);
        end
        n_tests++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_fail++; $display("FAIL reset_handshake got valid=%b ready=%b want 0/1", valid_out, ready_out);
        end
        n_tests++;
        if (q_out !== 12'h000 || ovf_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_q_ovf got q=%h ovf=%b want 000/0", q_out, ovf_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b1, 12'(i), 1'b0, 1'b0);
            n_tests++;
            if (count_out !== CW'(i) || q_out !== 12'h001) begin
                n_fail++; $display("FAIL fill_step%0d got count=%0d q=%h want %0d/001", i, count_out, q_out, i);
            end
        end
        n_tests++;
        if (full_out !== 1'b1 || ready_out !== 1'b0) begin
            n_fail++; $display("FAIL fill_full got full=%b ready=%b want 1/0", full_out, ready_out);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            n_tests++;
            if (q_out !== 12'(i) || valid_out !== 1'b1) begin
                n_fail++; $display("FAIL drain%0d got q=%h valid=%b want %h/1", i, q_out, valid_out, 12'(i));
            end
            tick(1'b0, 12'h000, 1'b1, 1'b0);
        end
        n_tests++;
        if (empty_out !== 1'b1 || q_out !== 12'h000) begin
            n_fail++; $display("FAIL drain_empty got empty=%b q=%h want 1/000", empty_out, q_out);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH; i++) tick(1'b1, 12'(i), 1'b0, 1'b0);
        n_tests++;
        if (ovf_out !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got %b want 0", ovf_out); end
        tick(1'b1, 12'hFFF, 1'b0, 1'b0);
        n_tests++;
        if (count_out !== CW'(DEPTH) || ovf_out !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set got count=%0d ovf=%b want 8/1", count_out, ovf_out);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            n_tests++;
            if (q_out !== 12'(i) || ovf_out !== 1'b1) begin
                n_fail++; $display("FAIL ovf_drain%0d got q=%h ovf=%b want %h/1", i, q_out, ovf_out, 12'(i));
            end
            tick(1'b0, 12'h000, 1'b1, 1'b0);
        end
        n_tests++;
        if (empty_out !== 1'b1 || ovf_out !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky got empty=%b ovf=%b want 1/1", empty_out, ovf_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] nxt;
        logic [11:0] exp_head;
        tick(1'b0, 12'h000, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) tick(1'b1, 12'(i), 1'b0, 1'b0);
        nxt      = 12'h004;
        exp_head = 12'h001;
        for (int c = 0; c < 20; c++) begin
            n_tests++;
            if (q_out !== exp_head) begin
                n_fail++; $display("FAIL b2b_order%0d got %h want %h", c, q_out, exp_head);
            end
            tick(1'b1, nxt, 1'b1, 1'b0);
            nxt++;
            exp_head++;
            n_tests++;
            if (count_out !== CW'(3)) begin
                n_fail++; $display("FAIL b2b_count%0d got %0d want 3", c, count_out);
            end
        end
        tick(1'b0, 12'h000, 1'b0, 1'b1);
        tick(1'b1, 12'h0AA, 1'b0, 1'b0);
        tick(1'b1, 12'h0BB, 1'b1, 1'b0);
        n_tests++;
        if (q_out !== 12'h0BB || count_out !== CW'(1)) begin
            n_fail++; $display("FAIL b2b_count1 got q=%h count=%0d want 0bb/1", q_out, count_out);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 12'h000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 12'(12'h050 + i), 1'b0, 1'b0);
        tick(1'b1, 12'h555, 1'b1, 1'b1);
        n_tests++;
        if (count_out !== CW'(0) || valid_out !== 1'b0 || q_out !== 12'h000) begin
            n_fail++; $display("FAIL rstmid_clear got count=%0d valid=%b q=%h want 0/0/000", count_out, valid_out, q_out);
        end
        tick(1'b1, 12'h123, 1'b0, 1'b0);
        n_tests++;
        if (q_out !== 12'h123 || count_out !== CW'(1)) begin
            n_fail++; $display("FAIL rstmid_push got q=%h count=%0d want 123/1", q_out, count_out);
        end
    endtask

    task automatic test_random();
        int unsigned p_valid;
        int unsigned p_ready;
        logic [11:0] exp_q;
        tick(1'b0, 12'h000, 1'b0, 1'b1);
        p_valid = 50;
        p_ready = 50;
        for (int c = 0; c < 10000; c++) begin
            // Shift the traffic mix periodically so both full and empty are visited.
            if (c % 400 == 0) begin
                p_valid = $urandom_range(20, 90);
                p_ready = $urandom_range(10, 90);
            end
            tick(1'($urandom_range(99, 0) < p_valid), 12'($urandom), 1'($urandom_range(99, 0) < p_ready), 1'b0);
            exp_q = (mq.size() > 0) ? mq[0] : 12'h000;
            n_tests++;
            if (count_out !== CW'(mq.size()) || q_out !== exp_q || ovf_out !== m_ovf
                || full_out !== (mq.size() == DEPTH) || empty_out !== (mq.size() == 0)) begin
                n_fail++;
                $display("FAIL rand_cycle%0d got count=%0d q=%h ovf=%b full=%b empty=%b want %0d/%h/%b/%b/%b",
                         c, count_out, q_out, ovf_out, full_out, empty_out,
                         mq.size(), exp_q, m_ovf, mq.size() == DEPTH, mq.size() == 0);
            end
        end
    endtask

    initial begin
        m_ovf = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
